fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
Sequences the instruction-fetch PC for the core front end. It issues one fetch request at a time to instruction memory. On each returned instruction it advances the PC using the static branch predictor's next_pc/is_jump outputs. It records every predicted-taken branch in a small in-order queue for execute to resolve, and performs flush/redirect when execute signals a misprediction.

Parameters:
RESET_PC, 32'h0000_0000, first PC fetched after reset
PQ_DEPTH, 4, prediction-queue entries (power of 2, >=2)
PQ_AW, 2, log2(PQ_DEPTH)

Ports:
clk  in  1  system clock, all state updates on rising edge
rstn  in  1  asynchronous, active-low reset
hold  in  1  downstream stall; blocks issue of a NEW fetch request
fetch_req  out  1  fetch request valid
fetch_pc  out  32  address of the requested instruction
fetch_ack  in  1  instruction for fetch_pc returned this cycle (fed to predictor externally)
pred_is_jump  in  1  predictor: acked instruction is branch/jal
pred_next_pc  in  32  predictor: next PC for acked instruction
ex_redirect  in  1  execute: mispredict, restart at ex_target
ex_target  in  32  correct PC for redirect
ex_resolve  in  1  execute: oldest queued prediction resolved, pop
pq_head_valid  out  1  queue non-empty
pq_head_pc  out  32  PC of oldest predicted branch
pq_head_target  out  32  predicted target of oldest entry
pq_count  out  PQ_AW+1  entries in queue
pq_full  out  1  pq_count == PQ_DEPTH

Behaviour:
- Reset (async, rstn=0): state BOOT; fetch_req=0; fetch_pc=RESET_PC; pending=0; pq_count=0; pq_head_valid=0; pq_full=0; pq_head_pc/target=0. Applies immediately, including mid-transaction; any in-flight memory response after reset is not tracked.
- FSM states: BOOT, RUN, DRAIN.
- BOOT: fetch_req=0 for exactly one cycle after rstn rises, then RUN.
- Handshake: a transaction completes in a cycle with fetch_req && fetch_ack. Zero-wait acks are allowed (ack in the issue cycle). Once asserted, fetch_req and fetch_pc stay stable until ack; hold does not withdraw a pending request. The pending flag is set on req && !ack and cleared on ack. At most one transaction is outstanding.
- RUN: fetch_req = pending | (!hold & !pq_full).
- Completion in RUN without redirect: fetch_pc <= pred_next_pc. If pred_is_jump, push {fetch_pc, pred_next_pc} at tail. The next request can issue in the following cycle (throughput 1 per cycle with zero-wait acks).
- Invariant: no push occurs while full, because issue is gated on !pq_full and count cannot grow while one request is pending. Verification asserts this.
- ex_resolve pops the head. It is ignored when the queue is empty. Push and pop in the same cycle leave pq_count unchanged, and ordering is preserved.
- ex_redirect has the highest priority:
  - The queue is flushed (count=0, head_valid=0 next cycle); any same-cycle push or ex_resolve is discarded.
  - ex_target is captured.
  - If no pending request, or the ack arrives in the same cycle: the ack is discarded, fetch_pc <= ex_target, state RUN.
  - If a request is pending and not acked: state DRAIN.
- DRAIN: fetch_req=1 and fetch_pc holds the stale PC until fetch_ack. The ack is discarded (no push, no PC update). Then fetch_pc <= captured target and state RUN. A further ex_redirect during DRAIN overwrites the captured target and keeps DRAIN. ex_resolve in DRAIN pops normally.
- Pointers are PQ_AW bits and wrap modulo PQ_DEPTH. pq_count is a separate PQ_AW+1-bit counter.
- PC arithmetic is external (the predictor supplies +4/+imm). No alignment checks; values pass through unmodified.
- Head outputs are registered queue contents, valid only when pq_head_valid=1, and update the cycle after a push-to-empty or pop.

Test Plan:
- Reset release, zero-wait memory, no branches -> fetch_req low 1 cycle, then fetch_pc 0x0, 0x4, 0x8, ... on consecutive cycles.
- Ack on PC 0x10 with pred_is_jump=1, pred_next_pc=0x40 -> next fetch_pc=0x40; pq_head_valid=1, head_pc=0x10, head_target=0x40, pq_count=1.
- Five predicted branches, no ex_resolve, PQ_DEPTH=4 -> pq_full after 4th; fetch_req drops and no 5th push; one ex_resolve -> request resumes, fetch continues.
- Request pending to 0x20 (ack delayed 3 cycles), ex_redirect to 0x100 -> DRAIN, stale ack discarded with no push, next fetch_pc=0x100, pq_count=0.
- ex_redirect, ex_resolve and branch ack in the same cycle with 2 entries queued -> pq_count=0, fetch_pc=ex_target, no push.
- Assert rstn low while in DRAIN with 3 entries queued -> outputs return to reset values immediately; BOOT, then fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - instruction-fetch PC sequencer with prediction queue
// One outstanding fetch; predicted-taken branches are queued in order for execute.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PQ_DEPTH = 4,
  parameter int          PQ_AW    = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hold,
  output logic             fetch_req,
  output logic [31:0]      fetch_pc,
  input  logic             fetch_ack,
  input  logic             pred_is_jump,
  input  logic [31:0]      pred_next_pc,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             ex_resolve,
  output logic             pq_head_valid,
  output logic [31:0]      pq_head_pc,
  output logic [31:0]      pq_head_target,
  output logic [PQ_AW:0]   pq_count,
  output logic             pq_full
);

  localparam logic [1:0]     S_BOOT  = 2'd0;
  localparam logic [1:0]     S_RUN   = 2'd1;
  localparam logic [1:0]     S_DRAIN = 2'd2;
  localparam logic [PQ_AW:0] LP_FULL = (PQ_AW+1)'(PQ_DEPTH);

  logic [1:0]       r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_target;
  logic             r_pending;
  logic [31:0]      r_pq_pc  [PQ_DEPTH];
  logic [31:0]      r_pq_tgt [PQ_DEPTH];
  logic [PQ_AW-1:0] r_wptr;
  logic [PQ_AW-1:0] r_rptr;
  logic [PQ_AW:0]   r_count;

  logic w_full;
  logic w_req;
  logic w_done;
  logic w_stall;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == LP_FULL);

  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      S_RUN:   w_req = r_pending | (~hold & ~w_full);
      S_DRAIN: w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  assign w_done  = w_req & fetch_ack;
  assign w_stall = w_req & ~fetch_ack;
  assign w_push  = (r_state == S_RUN) & w_done & pred_is_jump & ~ex_redirect;
  assign w_pop   = ex_resolve & (r_count != '0) & ~ex_redirect;

  // A request issued but not acked in the redirect cycle must still be drained,
  // so fetch_pc stays stable for the memory until its response arrives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_PC;
      r_target  <= '0;
      r_pending <= 1'b0;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          r_state   <= S_RUN;
          r_pending <= 1'b0;
        end
        S_RUN: begin
          r_pending <= w_stall;
          if (ex_redirect) begin
            if (w_stall) begin
              r_state  <= S_DRAIN;
              r_target <= ex_target;
            end else begin
              r_pc <= ex_target;
            end
          end else if (w_done) begin
            r_pc <= pred_next_pc;
          end
        end
        S_DRAIN: begin
          r_pending <= w_stall;
          if (ex_redirect) r_target <= ex_target;
          if (fetch_ack) begin
            r_state <= S_RUN;
            r_pc    <= ex_redirect ? ex_target : r_target;
          end
        end
        default: begin
          r_state   <= S_BOOT;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < PQ_DEPTH; i++) begin
        r_pq_pc[i]  <= '0;
        r_pq_tgt[i] <= '0;
      end
    end else if (ex_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pq_pc[r_wptr]  <= r_pc;
        r_pq_tgt[r_wptr] <= pred_next_pc;
        r_wptr           <= r_wptr + PQ_AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PQ_AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PQ_AW+1)'(1);
        2'b01:   r_count <= r_count - (PQ_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign fetch_req      = w_req;
  assign fetch_pc       = r_pc;
  assign pq_head_valid  = (r_count != '0);
  assign pq_head_pc     = r_pq_pc[r_rptr];
  assign pq_head_target = r_pq_tgt[r_rptr];
  assign pq_count       = r_count;
  assign pq_full        = w_full;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed and randomized bench for fetch_pc_ctrl
// Expected values come from a queue-based model of the fetch/predict/redirect rules.
module tb_fetch_pc_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rstn;
  logic        hold;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_ack;
  logic        pred_is_jump;
  logic [31:0] pred_next_pc;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        ex_resolve;
  logic        pq_head_valid;
  logic [31:0] pq_head_pc;
  logic [31:0] pq_head_target;
  logic [2:0]  pq_count;
  logic        pq_full;

  fetch_pc_ctrl #(.RESET_PC(RPC), .PQ_DEPTH(DEPTH), .PQ_AW(2)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .hold           (hold),
    .fetch_req      (fetch_req),
    .fetch_pc       (fetch_pc),
    .fetch_ack      (fetch_ack),
    .pred_is_jump   (pred_is_jump),
    .pred_next_pc   (pred_next_pc),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .ex_resolve     (ex_resolve),
    .pq_head_valid  (pq_head_valid),
    .pq_head_pc     (pq_head_pc),
    .pq_head_target (pq_head_target),
    .pq_count       (pq_count),
    .pq_full        (pq_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  bit          m_boot;
  bit          m_drain;
  bit          m_out;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit exp_req();
    if (m_boot)  return 1'b0;
    if (m_drain) return 1'b1;
    return m_out | (!hold && q.size() < DEPTH);
  endfunction

  task automatic check_all(input bit er);
    check("fetch_req", 32'(fetch_req), 32'(er));
    check("fetch_pc", fetch_pc, m_pc);
    check("pq_count", 32'(pq_count), 32'(q.size()));
    check("pq_full", 32'(pq_full), 32'(q.size() == DEPTH));
    check("pq_head_valid", 32'(pq_head_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("pq_head_pc", pq_head_pc, q[0].pc);
      check("pq_head_target", pq_head_target, q[0].tgt);
    end
  endtask

  task automatic model_update(input bit er);
    bit done;
    done = er && fetch_ack;
    if (m_boot) begin
      m_boot = 1'b0;
      m_out  = 1'b0;
      return;
    end
    if (ex_redirect) begin
      q.delete();
      if (m_drain) begin
        m_tgt = ex_target;
        if (fetch_ack) begin
          m_pc    = ex_target;
          m_drain = 1'b0;
        end
      end else if (er && !fetch_ack) begin
        m_drain = 1'b1;
        m_tgt   = ex_target;
      end else begin
        m_pc = ex_target;
      end
    end else begin
      if (ex_resolve && q.size() > 0) void'(q.pop_front());
      if (done) begin
        if (m_drain) begin
          m_pc    = m_tgt;
          m_drain = 1'b0;
        end else begin
          if (pred_is_jump) q.push_back({m_pc, pred_next_pc});
          m_pc = pred_next_pc;
        end
      end
    end
    m_out = er && !fetch_ack;
  endtask

  task automatic step(input bit h, input bit a, input bit j, input logic [31:0] nx,
                      input bit rd, input logic [31:0] tg, input bit rs);
    bit er;
    @(negedge clk);
    hold         = h;
    er           = exp_req();
    fetch_ack    = a & er;
    pred_is_jump = j;
    pred_next_pc = nx;
    ex_redirect  = rd;
    ex_target    = tg;
    ex_resolve   = rs;
    #1;
    check_all(er);
    model_update(er);
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn         = 1'b0;
    hold         = 1'b0;
    fetch_ack    = 1'b0;
    pred_is_jump = 1'b0;
    pred_next_pc = '0;
    ex_redirect  = 1'b0;
    ex_target    = '0;
    ex_resolve   = 1'b0;
    #1;
    check("rst_fetch_req", 32'(fetch_req), 32'd0);
    check("rst_fetch_pc", fetch_pc, RPC);
    check("rst_pq_count", 32'(pq_count), 32'd0);
    check("rst_pq_head_valid", 32'(pq_head_valid), 32'd0);
    check("rst_pq_full", 32'(pq_full), 32'd0);
    check("rst_pq_head_pc", pq_head_pc, 32'd0);
    check("rst_pq_head_target", pq_head_target, 32'd0);
    q.delete();
    m_boot  = 1'b1;
    m_drain = 1'b0;
    m_out   = 1'b0;
    m_pc    = RPC;
    m_tgt   = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn     = 1'b0;
    do_reset();

    // sequential fetch with zero-wait memory
    for (int i = 0; i < 5; i++) step(0, 1, 0, m_pc + 32'h4, 0, 0, 0);
    post_edge();
    check("seq_pc", fetch_pc, 32'h10);

    // predicted-taken branch at 0x10
    step(0, 1, 1, 32'h40, 0, 0, 0);
    post_edge();
    check("br_pc", fetch_pc, 32'h40);
    check("br_head_valid", 32'(pq_head_valid), 32'd1);
    check("br_head_pc", pq_head_pc, 32'h10);
    check("br_head_target", pq_head_target, 32'h40);
    check("br_count", 32'(pq_count), 32'd1);

    // fill the queue, fifth branch must be blocked
    step(0, 1, 0, m_pc + 32'h4, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 1, m_pc + 32'h100, 0, 0, 0);
    post_edge();
    check("full_count", 32'(pq_count), 32'd4);
    check("full_flag", 32'(pq_full), 32'd1);
    check("full_req", 32'(fetch_req), 32'd0);
    step(0, 1, 0, m_pc + 32'h4, 0, 0, 1);
    post_edge();
    check("resume_count", 32'(pq_count), 32'd3);
    check("resume_req", 32'(fetch_req), 32'd1);
    step(0, 1, 0, m_pc + 32'h4, 0, 0, 0);

    // delayed ack to 0x20, redirect to 0x100 drains the stale response
    step(1, 0, 0, 0, 1, 32'h20, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100, 0);
    post_edge();
    check("drain_pc", fetch_pc, 32'h20);
    check("drain_req", 32'(fetch_req), 32'd1);
    step(0, 1, 1, 32'h999, 0, 0, 0);
    post_edge();
    check("drain_done_pc", fetch_pc, 32'h100);
    check("drain_done_count", 32'(pq_count), 32'd0);

    // redirect + resolve + branch ack together with 2 entries queued
    for (int i = 0; i < 2; i++) step(0, 1, 1, m_pc + 32'h10, 0, 0, 0);
    step(0, 1, 1, 32'h300, 1, 32'h200, 1);
    post_edge();
    check("combo_count", 32'(pq_count), 32'd0);
    check("combo_pc", fetch_pc, 32'h200);

    // reset with a pending request and queued entries, then into DRAIN and reset again
    for (int i = 0; i < 3; i++) step(0, 1, 1, m_pc + 32'h20, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 1, 0, m_pc + 32'h4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h500, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, m_pc + 32'h4, 0, 0, 0);
    post_edge();
    check("reboot_pc", fetch_pc, RPC + 32'h8);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      step($urandom_range(4) == 0,
           $urandom_range(2) != 0,
           $urandom_range(2) == 0,
           $urandom & 32'hffff_fffc,
           !m_boot && ($urandom_range(11) == 0),
           $urandom & 32'hffff_fffc,
           $urandom_range(3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
